// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a byte-stream program image (word count + little-endian words)
// and writes it to instruction memory while holding the core in reset. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  // The header is a single byte, so no load can ask for more than 255 words.
  localparam int unsigned MAX_N = (DEPTH > 255) ? 255 : DEPTH;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_count;
  logic [7:0]  r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_wd;
  logic        r_done, r_error;
  logic        w_ready, w_hold, w_we, w_accept, w_hdr_bad, w_last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  assign w_accept    = byte_valid & w_ready;
  assign w_hdr_bad   = (byte_data == 8'd0) || ({24'd0, byte_data} > MAX_N);
  assign w_last_word = ({1'b0, r_word_idx} + 9'd1) >= {1'b0, r_count};

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_we    = 1'b0;
    w_hold  = 1'b1;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        w_hold = (r_state == S_ERR);
        if (start) w_next = S_HDR;
      end
      S_HDR: begin
        w_ready = 1'b1;
        if (w_accept) w_next = w_hdr_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        w_ready = 1'b1;
        if (w_accept && r_byte_idx == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_we = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_next = w_last_word ? S_CHK : S_DATA;
`else
        w_next = w_last_word ? S_DONE : S_DATA;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        w_ready = 1'b1;
        if (w_accept) w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
      r_error <= (w_next == S_ERR);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= 8'd0;
      r_word_idx <= 8'd0;
      r_byte_idx <= 2'd0;
      r_wd       <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_word_idx <= 8'd0;
            r_byte_idx <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
          end
        end
        S_HDR: begin
          if (w_accept) r_count <= byte_data;
        end
        S_DATA: begin
          if (w_accept) begin
            r_wd[{r_byte_idx, 3'b000} +: 8] <= byte_data;
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ byte_data;
`endif
          end
        end
        S_WRITE: r_word_idx <= r_word_idx + 8'd1;
        default: ;
      endcase
    end
  end

  // Word index never exceeds N <= DEPTH, so addresses cannot wrap.
  assign mem_addr   = {22'd0, r_word_idx, 2'b00};
  assign mem_wd     = r_wd;
  assign mem_we     = w_we;
  assign byte_ready = w_ready;
  assign cpu_hold   = w_hold;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver queues the expected memory writes of each program image,
// a negedge monitor pops and compares them. Honours IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset_n, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wd;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] wbuf[256];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_acc = 0;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation, one cycle after its last byte.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wd, e.wd);
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  // All driver tasks begin and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (byte_ready) begin
        last_acc = cyc;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        return;
      end
    end
    check("byte_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input bit exp_ok);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done || error) break;
    end
    if (k == 100) check("end_timeout", 32'd0, 32'd1);
    check("done", {31'd0, done}, {31'd0, exp_ok});
    check("error", {31'd0, error}, {31'd0, !exp_ok});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_ok});
    check("byte_ready_end", {31'd0, byte_ready}, 32'd0);
    check("pending_writes", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Reference: a good header yields writes 4*i <- wbuf[i] for i < n; the load succeeds iff the header
  // is in 1..DEPTH and (when enabled) the trailing byte equals the XOR of all data bytes.
  task automatic run_load(input int n, input int maxgap, input bit bad_csum, input bit start_mid);
    bit         hdr_ok;
    logic [7:0] csum;
    logic [7:0] b;
    hdr_ok = (n >= 1) && (n <= DEPTH);
    csum   = 8'd0;
    do_start();
    send_byte(8'(n), $urandom_range(0, maxgap));
    if (hdr_ok) begin
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < 4; j++) begin
          b    = wbuf[i][8*j +: 8];
          csum = csum ^ b;
          if (start_mid && j == 2) do_start();
          send_byte(b, (maxgap < 0) ? ((j == 0 && i == 0) ? 0 : 1) : $urandom_range(0, maxgap));
          if (j == 3) exp_q.push_back('{addr: 32'(4 * i), wd: wbuf[i], cyc: last_acc + 1});
        end
      end
      if (CSUM_EN) send_byte(bad_csum ? ((csum == 8'd0) ? 8'hFF : 8'h00) : csum, 0);
    end
    wait_end(hdr_ok && !(CSUM_EN && bad_csum));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wd"}, mem_wd, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("idle_no_start");

    // Single word, valid held high.
    wbuf[0] = 32'h00500093;
    run_load(1, 0, 1'b0, 1'b0);

    // Two words, valid toggling every cycle.
    wbuf[0] = 32'h0040A113; wbuf[1] = 32'hFE514113;
    run_load(2, -1, 1'b0, 1'b0);

    // Bad headers, each followed by a start that must return to HDR.
    for (int t = 0; t < 2; t++) begin
      run_load((t == 0) ? 0 : DEPTH + 1, 1, 1'b0, 1'b0);
      do_start();
      @(negedge clk);
      check("recover_byte_ready", {31'd0, byte_ready}, 32'd1);
      check("recover_error", {31'd0, error}, 32'd0);
      check("recover_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      @(posedge clk); #1;
    end

    // Maximum-size image (start is ignored in HDR, so run_load continues from here).
    for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
    run_load(DEPTH, 0, 1'b0, 1'b0);

    if (CSUM_EN) begin
      wbuf[0] = 32'h00500093;
      run_load(1, 1, 1'b0, 1'b0);
      run_load(1, 1, 1'b1, 1'b0);
    end

    // Reset after two data bytes of the first word.
    do_start();
    send_byte(8'd2, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    wbuf[0] = $urandom; wbuf[1] = $urandom;
    run_load(2, 1, 1'b0, 1'b0);

    // Start pulsed mid-word is ignored.
    wbuf[0] = $urandom; wbuf[1] = $urandom; wbuf[2] = $urandom;
    run_load(3, 1, 1'b0, 1'b1);

    // Randomized images, gaps and occasional out-of-range headers.
    for (int r = 0; r < 20; r++) begin
      int n;
      n = (r % 7 == 6) ? $urandom_range(DEPTH + 1, 255) : $urandom_range(1, 6);
      for (int i = 0; i < 6; i++) wbuf[i] = $urandom;
      run_load(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
